mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LSB, default 2: byte-to-word address shift applied to master addresses.
REQ-002 SHALL have parameter OWN_DEPTH, default 2: depth of the outstanding-response owner FIFO (power of two, >=2).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 m0_req_i / m1_req_i  in  1  master request.
REQ-006 m0_gnt_o / m1_gnt_o  out  1  master grant, same cycle as accepted request.
REQ-007 m0_rvalid_o / m1_rvalid_o  out  1  response valid for that master.
REQ-008 m0_addr_i / m1_addr_i  in  32  byte address.
REQ-009 m0_we_i / m1_we_i  in  1  write enable.
REQ-010 m0_wdata_i / m1_wdata_i  in  32  write data.
REQ-011 m0_rdata_o / m1_rdata_o  out  32  read data, meaningful only with own rvalid.
REQ-012 mem_req_o  out  1  request to memory port.
REQ-013 mem_gnt_i  in  1  memory grant.
REQ-014 mem_rvalid_i  in  1  memory response valid.
REQ-015 mem_addr_o  out  32  word address to memory.
REQ-016 mem_we_o  out  1  write enable to memory.
REQ-017 mem_wdata_o  out  32  write data to memory.
REQ-018 mem_rdata_i  in  32  memory read data.
REQ-019 err_o  out  1  sticky error: response with no recorded owner.

Function
REQ-020 Selection SHALL be combinational: one requester -> that master; both -> master holding priority pointer.
REQ-021 Priority pointer SHALL flip to the other master on every accepted grant; unchanged when no grant.
REQ-022 mem_req_o SHALL be (m0_req_i | m1_req_i) & ~fifo_full; when fifo_full, mem_req_o=0 and no master grant.
REQ-023 mem_addr_o SHALL be selected address >> ADDR_LSB, zero-extended; mem_we_o, mem_wdata_o SHALL pass selected master's values; all three SHALL be 0 when mem_req_o=0.
REQ-024 Master gnt SHALL be asserted only for the selected master and only when mem_req_o & mem_gnt_i; never both in one cycle.
REQ-025 Each accepted grant (reads and writes) SHALL push the owner id into the owner FIFO.
REQ-026 On mem_rvalid_i with FIFO non-empty, owner at head SHALL get rvalid=1 and rdata=mem_rdata_i in the same cycle; head popped at the edge.
REQ-027 Non-owner rdata SHALL be 32'h0; both rdata SHALL be 0 when no rvalid.
REQ-028 Simultaneous push and pop SHALL both occur; occupancy unchanged; allowed even when full (push only if grant, grant blocked when full -- pop frees slot next cycle, not same cycle).
REQ-029 mem_rvalid_i with FIFO empty SHALL set err_o, produce no master rvalid, and leave state unchanged.
REQ-030 Back-to-back grants every cycle SHALL be sustained with a one-cycle-latency memory (OWN_DEPTH>=2).
REQ-031 FIFO pointers SHALL wrap modulo OWN_DEPTH; occupancy counter width clog2(OWN_DEPTH)+1.

Reset
REQ-032 On rst_n=0: FIFO emptied, priority pointer = m0, err_o=0; all outputs 0 while in reset.
REQ-033 Reset mid-transaction SHALL discard outstanding owners; a response arriving after release SHALL raise err_o.
REQ-034 err_o SHALL clear only by reset.

Verification
REQ-035 Only m0 reads byte addr 0x10, mem_gnt_i=1 -> mem_addr_o=0x4, m0_gnt_o=1 same cycle; next cycle mem_rvalid_i with 0xCAFE -> m0_rvalid_o=1, m0_rdata_o=0xCAFE, m1_rdata_o=0.
REQ-036 Both masters request continuously 6 cycles after reset -> grants m0,m1,m0,m1,m0,m1; rvalids route in same order one cycle later.
REQ-037 mem_rvalid_i never returned, both request -> exactly 2 grants, then mem_req_o=0 until a response pops.
REQ-038 mem_rvalid_i pulsed with FIFO empty -> err_o=1 next cycle and stays 1; no master rvalid.
REQ-039 m1 write grant then rst_n pulsed before response; response arrives after release -> no m1_rvalid_o, err_o=1.
REQ-040 mem_gnt_i=0 with both requesting -> no master gnt, priority pointer unchanged; on mem_gnt_i=1 original priority holder wins.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single pipelined memory port.
// Requests are selected combinationally with a flipping priority pointer.
// A small owner FIFO records which master each accepted request came from,
// so that in-order memory responses can be routed back to the right master.
module mem_arbiter #(
    parameter int ADDR_LSB  = 2,
    parameter int OWN_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,

    output logic        err_o
);

    localparam int PW = (OWN_DEPTH > 1) ? $clog2(OWN_DEPTH) : 1;
    localparam int CW = $clog2(OWN_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OWN_DEPTH);

    // Owner FIFO storage: 0 = m0, 1 = m1.
    logic          owner_q [OWN_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          prio;
    logic          err_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          sel;
    logic          accept;
    logic          pop;
    logic          head_owner;
    logic [31:0]   sel_addr;
    logic          sel_we;
    logic [31:0]   sel_wdata;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign head_owner = owner_q[rd_ptr];

    // Pick the master: a lone requester wins, otherwise the priority holder wins.
    always_comb begin
        sel = 1'b0;
        unique case ({m1_req_i, m0_req_i})
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = prio;
            default: sel = 1'b0;
        endcase
    end

    assign sel_addr  = sel ? m1_addr_i  : m0_addr_i;
    assign sel_we    = sel ? m1_we_i    : m0_we_i;
    assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;

    // Requests are held off while reset is asserted or no owner slot is free.
    assign mem_req_o   = rst_n & (m0_req_i | m1_req_i) & ~fifo_full;
    assign mem_addr_o  = mem_req_o ? (sel_addr >> ADDR_LSB) : 32'h0;
    assign mem_we_o    = mem_req_o ? sel_we : 1'b0;
    assign mem_wdata_o = mem_req_o ? sel_wdata : 32'h0;

    assign accept   = mem_req_o & mem_gnt_i;
    assign m0_gnt_o = accept & ~sel;
    assign m1_gnt_o = accept &  sel;

    // A response is only routed when an owner is recorded for it.
    assign pop         = mem_rvalid_i & ~fifo_empty;
    assign m0_rvalid_o = pop & ~head_owner;
    assign m1_rvalid_o = pop &  head_owner;
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : 32'h0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : 32'h0;

    assign err_o = err_q;

    // Owner storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_q[wr_ptr] <= sel;
        end
    end

    // FIFO pointers, occupancy, priority pointer and the sticky orphan-response flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prio   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
                prio   <= ~prio;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (mem_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a queue-based model of owners and priority.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req_i, m1_req_i;
    logic        m0_gnt_o, m1_gnt_o;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_we_i, m1_we_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_LSB(2), .OWN_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i),
        .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i),
        .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        m0_req_i = 0; m1_req_i = 0;
        m0_addr_i = 0; m1_addr_i = 0;
        m0_we_i = 0; m1_we_i = 0;
        m0_wdata_i = 0; m1_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    // Leaves the bench just after a falling edge, with reset released.
    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        m0_req_i = 1; m1_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
        m0_addr_i = 32'h40; m0_we_i = 1; m0_wdata_i = 32'h1234;
        #1;
        checks++;
        if ({mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_we_o} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: actual=%b required=000000",
                     {mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, mem_we_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, m0_rdata_o, m1_rdata_o} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: actual=%h required=0",
                     {mem_addr_o, mem_wdata_o, m0_rdata_o, m1_rdata_o});
        end
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err: actual=%b required=0", err_o);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h10; m0_we_i = 0; mem_gnt_i = 1;
        #1;
        checks++;
        if (mem_addr_o !== 32'h4) begin
            errors++;
            $display("[TB] FAIL single_addr: actual=%h required=4", mem_addr_o);
        end
        checks++;
        if ({mem_req_o, m0_gnt_o, m1_gnt_o, mem_we_o} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL single_gnt: actual=%b required=1100",
                     {mem_req_o, m0_gnt_o, m1_gnt_o, mem_we_o});
        end
        @(negedge clk);
        idle_inputs();
        mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
        #1;
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_rvalid: actual=%b required=10", {m0_rvalid_o, m1_rvalid_o});
        end
        checks++;
        if (m0_rdata_o !== 32'hCAFE || m1_rdata_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL single_rdata: actual=%h/%h required=0000cafe/00000000",
                     m0_rdata_o, m1_rdata_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            m0_req_i = (i < 6); m1_req_i = (i < 6); mem_gnt_i = 1;
            m0_addr_i = 32'h100; m1_addr_i = 32'h200;
            mem_rvalid_i = (i > 0); mem_rdata_i = 32'hA0 + i;
            #1;
            checks++;
            if (i < 6 && {m0_gnt_o, m1_gnt_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("[TB] FAIL b2b_gnt[%0d]: actual=%b required=%b", i,
                         {m0_gnt_o, m1_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end else if (i == 6 && {m0_gnt_o, m1_gnt_o} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL b2b_gnt[%0d]: actual=%b required=00", i, {m0_gnt_o, m1_gnt_o});
            end
            if (i > 0) begin
                checks++;
                if ({m0_rvalid_o, m1_rvalid_o} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("[TB] FAIL b2b_rvalid[%0d]: actual=%b required=%b", i,
                             {m0_rvalid_o, m1_rvalid_o}, ((i - 1) % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_full_stall();
        int grants = 0;
        do_reset();
        m0_req_i = 1; m1_req_i = 1; mem_gnt_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            grants += int'(m0_gnt_o) + int'(m1_gnt_o);
            if (i >= 2) begin
                checks++;
                if (mem_req_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full_req[%0d]: actual=%b required=0", i, mem_req_o);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (grants != 2) begin
            errors++;
            $display("[TB] FAIL full_grants: actual=%0d required=2", grants);
        end
        mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        #1;
        checks++;
        if ({mem_req_o, m0_rvalid_o, m1_rvalid_o} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL full_pop: actual=%b required=010", {mem_req_o, m0_rvalid_o, m1_rvalid_o});
        end
        @(negedge clk);
        mem_rvalid_i = 0;
        #1;
        checks++;
        if ({mem_req_o, m0_gnt_o, m1_gnt_o} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL full_resume: actual=%b required=110", {mem_req_o, m0_gnt_o, m1_gnt_o});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_err_empty();
        do_reset();
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD;
        #1;
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL orphan_resp: actual=%b required=000", {m0_rvalid_o, m1_rvalid_o, err_o});
        end
        @(negedge clk);
        mem_rvalid_i = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (err_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL err_sticky[%0d]: actual=%b required=1", i, err_o);
            end
            m0_req_i = (i == 1); mem_gnt_i = 1;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        m1_req_i = 1; m1_we_i = 1; m1_wdata_i = 32'h600DF00D; m1_addr_i = 32'h20; mem_gnt_i = 1;
        #1;
        checks++;
        if ({m1_gnt_o, mem_we_o} !== 2'b11 || mem_wdata_o !== 32'h600DF00D || mem_addr_o !== 32'h8) begin
            errors++;
            $display("[TB] FAIL mid_write: actual=%b %h %h required=11 600df00d 00000008",
                     {m1_gnt_o, mem_we_o}, mem_wdata_o, mem_addr_o);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        #1;
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00 || m1_rdata_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_no_rvalid: actual=%b %h required=00 0", {m0_rvalid_o, m1_rvalid_o}, m1_rdata_o);
        end
        @(negedge clk);
        mem_rvalid_i = 0;
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_err: actual=%b required=1", err_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_no_gnt();
        do_reset();
        m0_req_i = 1; mem_gnt_i = 1;
        @(negedge clk);
        m1_req_i = 1; mem_gnt_i = 0; mem_rvalid_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({mem_req_o, m0_gnt_o, m1_gnt_o} !== 3'b100) begin
                errors++;
                $display("[TB] FAIL nognt[%0d]: actual=%b required=100", i, {mem_req_o, m0_gnt_o, m1_gnt_o});
            end
            @(negedge clk);
            mem_rvalid_i = 0;
        end
        mem_gnt_i = 1;
        #1;
        checks++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL nognt_holder: actual=%b required=01", {m0_gnt_o, m1_gnt_o});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        int          q[$];
        bit          prio = 0;
        bit          err = 0;
        bit          full, ereq, esel, egnt, erv0, erv1;
        logic [31:0] eaddr, ewdata;
        bit          ewe;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            m0_req_i = 1'($urandom_range(0, 1));
            m1_req_i = 1'($urandom_range(0, 1));
            m0_addr_i = $urandom(); m1_addr_i = $urandom();
            m0_we_i = 1'($urandom_range(0, 1)); m1_we_i = 1'($urandom_range(0, 1));
            m0_wdata_i = $urandom(); m1_wdata_i = $urandom();
            mem_gnt_i = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
            mem_rdata_i = $urandom();

            full  = (q.size() >= 2);
            ereq  = (m0_req_i || m1_req_i) && !full;
            esel  = (m0_req_i && m1_req_i) ? prio : m1_req_i;
            egnt  = ereq && mem_gnt_i;
            eaddr  = ereq ? ((esel ? m1_addr_i : m0_addr_i) >> 2) : 32'h0;
            ewdata = ereq ? (esel ? m1_wdata_i : m0_wdata_i) : 32'h0;
            ewe    = ereq && (esel ? m1_we_i : m0_we_i);
            erv0  = mem_rvalid_i && q.size() > 0 && q[0] == 0;
            erv1  = mem_rvalid_i && q.size() > 0 && q[0] == 1;

            #1;
            checks++;
            if ({mem_req_o, mem_we_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !==
                {ereq, ewe, egnt && !esel, egnt && esel, erv0, erv1}) begin
                errors++;
                $display("[TB] FAIL rnd_ctrl[%0d]: actual=%b required=%b", c,
                         {mem_req_o, mem_we_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o},
                         {ereq, ewe, egnt && !esel, egnt && esel, erv0, erv1});
            end
            checks++;
            if (mem_addr_o !== eaddr || mem_wdata_o !== ewdata) begin
                errors++;
                $display("[TB] FAIL rnd_mem[%0d]: actual=%h/%h required=%h/%h", c,
                         mem_addr_o, mem_wdata_o, eaddr, ewdata);
            end
            checks++;
            if (m0_rdata_o !== (erv0 ? mem_rdata_i : 32'h0) || m1_rdata_o !== (erv1 ? mem_rdata_i : 32'h0)) begin
                errors++;
                $display("[TB] FAIL rnd_rdata[%0d]: actual=%h/%h", c, m0_rdata_o, m1_rdata_o);
            end
            checks++;
            if (err_o !== err) begin
                errors++;
                $display("[TB] FAIL rnd_err[%0d]: actual=%b required=%b", c, err_o, err);
            end

            if (mem_rvalid_i) begin
                if (q.size() > 0) void'(q.pop_front());
                else err = 1;
            end
            if (egnt) begin
                q.push_back(int'(esel));
                prio = !prio;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_full_stall();
        test_err_empty();
        test_reset_midflight();
        test_no_gnt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
